instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch front end that drives the word address into the instruction memory and collects the returned instruction words. It accounts for the memory's one-cycle registered read latency and buffers fetched words in a small in-order queue. It presents the words to decode over a valid/ready handshake, and supports branch redirect (with flush) and halt. It sits between the PC logic and the decode stage, directly on the instruction memory's address/data pair.

## Interface
- RESET_PC, 32'h0: fetch address loaded on reset.
- QUEUE_DEPTH, 4: instruction queue entries; power of two, ≥2.

- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- out_pc  output  32  word address to instruction memory.
- in_inst  input  32  instruction memory data; equals mem[A] in the cycle after an edge that sampled out_pc=A.
- redirect  input  1  flush and restart fetch at redirect_pc.
- redirect_pc  input  32  new fetch address; used only when redirect=1.
- halt  input  1  suppress new fetch issue.
- inst_valid  output  1  queue head valid toward decode.
- inst  output  32  queue head instruction word.
- inst_pc  output  32  address the queue head was fetched from.
- inst_ready  input  1  decode accepts head this cycle.

## Operation
- Addresses are word addresses. out_pc increments by 1 per issued fetch, not by 4.
- State:
  - out_pc register.
  - In-flight slot: inflight_valid, inflight_pc.
  - Circular queue of {pc, inst} with rd/wr pointers and count (0..QUEUE_DEPTH).
- issue = !halt && !redirect && (count + inflight_valid) < QUEUE_DEPTH.
  - Evaluated from current-cycle state only. A same-cycle pop does not add credit.
- Each edge (rst=0, redirect=0):
  - If issue: inflight_valid←1, inflight_pc←out_pc, out_pc←out_pc+1. Otherwise inflight_valid←0 and out_pc holds.
  - If inflight_valid: push {inflight_pc, in_inst} at wr pointer.
  - If inst_valid && inst_ready: pop head.
  - Push and pop in the same cycle leave count unchanged.
  - The credit rule makes the queue never overflow, so no push is ever dropped.
- inst_valid = (count != 0) && !redirect. inst and inst_pc are the head entry.
- Redirect (edge with redirect=1, rst=0):
  - Queue cleared: count←0, pointers←0.
  - inflight_valid←0; the arriving in_inst is discarded.
  - out_pc←redirect_pc.
  - No issue, push or pop occurs that edge.
  - inst_valid is forced 0 during the redirect cycle, so no handshake completes.
- Halt: no new issue. The in-flight word is still captured and the queue still drains. On deassert, fetch resumes at the held out_pc.
- out_pc wraps 32'hFFFFFFFF → 0. No truncation to memory size.
- Reset (rst=1 at edge) overrides redirect and halt, and has the same effect at any point in operation:
  - out_pc←RESET_PC.
  - inflight_valid←0, count←0, pointers←0.
  - All queue entries←0.

## Timing
- Reset values: out_pc=RESET_PC, inst_valid=0, inst=0, inst_pc=0.
- Fetch latency:
  - Edge E0 (first with rst=0): issues RESET_PC.
  - Edge E1: pushes that word.
  - inst_valid=1 in the cycle after E1.
- Same latency after a redirect edge: the first word from redirect_pc is valid two cycles after the redirect edge.
- Throughput is one instruction per cycle with inst_ready held 1. A stall of inst_ready=0 leads to a full queue, and issue stops.
- inst/inst_pc stay stable while inst_valid=1 and inst_ready=0.
- Outputs are registered except inst_valid's redirect gating.

## Test plan
- Reset release, RESET_PC=0, memory model mem[i]=0x100+i, inst_ready=1 → inst_valid first high two cycles after release. Then inst_pc=0,1,2,… and inst=0x100,0x101,… every cycle, with no gaps.
- inst_ready=0 from start → out_pc stops at 4 after issuing 0..3, and inst_valid stays 1 with inst_pc=0. Raise inst_ready → inst_pc 0,1,2,3,4,… in order, none lost or duplicated.
- With 2 queued entries plus 1 in flight, pulse redirect with redirect_pc=0x20 → inst_valid=0 in the pulse cycle and the next cycle. Next accepted inst_pc=0x20, inst=0x120. Stale PCs never appear.
- halt=1 mid-stream at out_pc=7 → out_pc holds 7, the in-flight word (pc 6) still appears, and the queue drains to empty. halt=0 → next inst_pc=7.
- redirect_pc=32'hFFFFFFFF, inst_ready=1 → inst_pc sequence FFFFFFFF, 00000000, 00000001.
- rst=1 for one cycle with a full queue and redirect=1 → after the edge inst_valid=0, out_pc=RESET_PC, inst=0, inst_pc=0. Refetch starts at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch front end: drives word addresses to a one-cycle-latency
// instruction memory and buffers returned words in an in-order queue for decode.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC    = 32'h0,
    parameter int unsigned QUEUE_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] out_pc,
    input  logic [31:0] in_inst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);

    logic [31:0]      out_pc_q, out_pc_d;
    logic             inflight_valid_q, inflight_valid_d;
    logic [31:0]      inflight_pc_q, inflight_pc_d;
    logic [31:0]      q_pc_q   [QUEUE_DEPTH];
    logic [31:0]      q_pc_d   [QUEUE_DEPTH];
    logic [31:0]      q_inst_q [QUEUE_DEPTH];
    logic [31:0]      q_inst_d [QUEUE_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [CNT_W:0]   occupancy;
    logic             issue;
    logic             push;
    logic             pop;

    // Credit check counts the in-flight word so a full queue can never be overrun.
    assign occupancy = {1'b0, count_q} + (CNT_W+1)'(inflight_valid_q);
    assign issue     = !halt && !redirect && (occupancy < (CNT_W+1)'(QUEUE_DEPTH));
    assign push      = inflight_valid_q;

    assign inst_valid = (count_q != '0) && !redirect;
    assign pop        = inst_valid && inst_ready;
    assign out_pc     = out_pc_q;
    assign inst       = q_inst_q[rd_ptr_q];
    assign inst_pc    = q_pc_q[rd_ptr_q];

    always_comb begin
        out_pc_d         = out_pc_q;
        inflight_valid_d = inflight_valid_q;
        inflight_pc_d    = inflight_pc_q;
        q_pc_d           = q_pc_q;
        q_inst_d         = q_inst_q;
        rd_ptr_d         = rd_ptr_q;
        wr_ptr_d         = wr_ptr_q;
        count_d          = count_q;

        if (redirect) begin
            // Flush: drop queue and the arriving word, restart at the new target.
            out_pc_d         = redirect_pc;
            inflight_valid_d = 1'b0;
            rd_ptr_d         = '0;
            wr_ptr_d         = '0;
            count_d          = '0;
        end else begin
            inflight_valid_d = issue;
            if (issue) begin
                inflight_pc_d = out_pc_q;
                out_pc_d      = out_pc_q + 32'd1;
            end
            if (push) begin
                q_pc_d[wr_ptr_q]   = inflight_pc_q;
                q_inst_d[wr_ptr_q] = in_inst;
                wr_ptr_d           = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_pc_q         <= RESET_PC;
            inflight_valid_q <= 1'b0;
            inflight_pc_q    <= '0;
            rd_ptr_q         <= '0;
            wr_ptr_q         <= '0;
            count_q          <= '0;
            for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
                q_pc_q[i]   <= '0;
                q_inst_q[i] <= '0;
            end
        end else begin
            out_pc_q         <= out_pc_d;
            inflight_valid_q <= inflight_valid_d;
            inflight_pc_q    <= inflight_pc_d;
            rd_ptr_q         <= rd_ptr_d;
            wr_ptr_q         <= wr_ptr_d;
            count_q          <= count_d;
            for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
                q_pc_q[i]   <= q_pc_d[i];
                q_inst_q[i] <= q_inst_d[i];
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a registered memory model mem[i] = 0x100 + i.
module tb_instruction_fetch;

    logic        clk;
    logic        rst;
    logic [31:0] out_pc;
    logic [31:0] in_inst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    int n_checks = 0;
    int n_fail   = 0;

    instruction_fetch #(
        .RESET_PC    (32'h0),
        .QUEUE_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .out_pc      (out_pc),
        .in_inst     (in_inst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle registered read memory
    always @(posedge clk) in_inst <= out_pc + 32'h100;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Consume n words starting at start_pc (inst_ready must be 1), within budget cycles.
    task automatic stream(input string tag, input logic [31:0] start_pc, input int n, input int budget);
        logic [31:0] exp;
        int got;
        exp = start_pc;
        got = 0;
        for (int i = 0; i < budget && got < n; i++) begin
            if (inst_valid && inst_ready) begin
                check({tag, "_pc"}, inst_pc, exp);
                check({tag, "_inst"}, inst, exp + 32'h100);
                exp = exp + 32'd1;
                got++;
            end
            step();
        end
        check({tag, "_count"}, 32'(got), 32'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp;
        rst = 1'b1;
        redirect = 1'b0;
        redirect_pc = '0;
        halt = 1'b0;
        inst_ready = 1'b1;
        @(negedge clk);

        // Reset state and first-fetch latency
        do_reset();
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_valid", 32'(inst_valid), 32'h0);
        check("rst_inst", inst, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);
        step();
        check("lat_e0_valid", 32'(inst_valid), 32'h0);
        step();
        check("lat_e1_valid", 32'(inst_valid), 32'h1);
        check("lat_e1_pc", inst_pc, 32'h0);
        check("lat_e1_inst", inst, 32'h100);
        stream("seq", 32'h0, 8, 8);

        // Stall until full, then drain in order
        inst_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 8; i++) step();
        check("full_out_pc", out_pc, 32'h4);
        check("full_valid", 32'(inst_valid), 32'h1);
        check("full_head_pc", inst_pc, 32'h0);
        inst_ready = 1'b1;
        stream("drain", 32'h0, 10, 30);

        // Redirect with 2 queued + 1 in flight
        inst_ready = 1'b0;
        do_reset();
        step();
        step();
        step();
        check("pre_redir_valid", 32'(inst_valid), 32'h1);
        inst_ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h20;
        #1;
        check("redir_cycle_valid", 32'(inst_valid), 32'h0);
        step();
        redirect = 1'b0;
        check("redir_r0_valid", 32'(inst_valid), 32'h0);
        step();
        check("redir_r1_valid", 32'(inst_valid), 32'h0);
        step();
        check("redir_r2_valid", 32'(inst_valid), 32'h1);
        stream("redir", 32'h20, 4, 4);

        // Halt mid-stream at out_pc=7
        inst_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 7; i++) step();
        check("halt_out_pc", out_pc, 32'h7);
        check("halt_head_pc", inst_pc, 32'h5);
        halt = 1'b1;
        exp = 32'h5;
        for (int i = 0; i < 4; i++) begin
            if (inst_valid) begin
                check("halt_drain_pc", inst_pc, exp);
                exp = exp + 32'd1;
            end
            step();
            check("halt_hold_pc", out_pc, 32'h7);
        end
        check("halt_last_seen", exp, 32'h7);
        check("halt_empty", 32'(inst_valid), 32'h0);
        halt = 1'b0;
        stream("resume", 32'h7, 3, 6);

        // Address wrap at the top of the address space
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        step();
        redirect = 1'b0;
        stream("wrap", 32'hFFFF_FFFF, 3, 6);

        // Reset with full queue and redirect asserted
        inst_ready = 1'b0;
        for (int i = 0; i < 8; i++) step();
        check("prerst_valid", 32'(inst_valid), 32'h1);
        rst = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h55;
        step();
        rst = 1'b0;
        redirect = 1'b0;
        check("rst2_valid", 32'(inst_valid), 32'h0);
        check("rst2_out_pc", out_pc, 32'h0);
        check("rst2_inst", inst, 32'h0);
        check("rst2_inst_pc", inst_pc, 32'h0);
        inst_ready = 1'b1;
        stream("refetch", 32'h0, 3, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
